// File: rtl/servile_arb_pkg.sv
// rtl/servile_arb_pkg.sv - shared types and constants for the SERV SRAM arbiter
package servile_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT_RD,
        ACK
    } arb_state_t;

    // Byte address where the register file begins: it fills the top of the SRAM.
    function automatic int rf_base(input int depth, input int rf_regs);
        return depth - 4 * rf_regs;
    endfunction

endpackage

// File: rtl/servile_sram_arbiter.sv
// rtl/servile_sram_arbiter.sv - shares one byte-wide SRAM between the SERV register file and the Wishbone data bus
module servile_sram_arbiter
    import servile_arb_pkg::*;
#(
    parameter int depth   = 1024,
    parameter int rf_regs = 36,
    localparam int aw     = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic [7:0]    i_rf_waddr,
    input  logic [7:0]    i_rf_wdata,
    input  logic          i_rf_wen,
    input  logic [7:0]    i_rf_raddr,
    input  logic          i_rf_ren,
    output logic [7:0]    o_rf_rdata,

    input  logic [aw-1:2] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_stb,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,

    output logic [aw-1:0] o_sram_waddr,
    output logic [7:0]    o_sram_wdata,
    output logic          o_sram_wen,
    output logic [aw-1:0] o_sram_raddr,
    output logic          o_sram_ren,
    input  logic [7:0]    i_sram_rdata
);

    localparam logic [aw-1:0] RF_BASE = aw'(rf_base(depth, rf_regs));

    arb_state_t     state;
    arb_state_t     state_nxt;

    logic [aw-1:2]  adr_q;
    logic [31:0]    dat_q;
    logic [3:0]     sel_q;
    logic           we_q;
    logic [1:0]     cnt;
    logic           rd_pend;
    logic [1:0]     rd_lane;

    logic           rf_busy;
    logic           wb_issue;
    logic           wb_start;
    logic [aw-1:0]  wb_addr;

    // Any RF activity steals the whole cycle from the bus, keeping RF latency fixed.
    assign rf_busy  = i_rf_wen | i_rf_ren;
    assign wb_issue = (state == XFER) && !rf_busy;
    assign wb_start = (state == IDLE) && i_wb_stb && !o_wb_ack;
    assign wb_addr  = {adr_q, cnt};

    assign o_wb_ack   = (state == ACK);
    assign o_rf_rdata = i_sram_rdata;

    always_comb begin
        o_sram_waddr = wb_addr;
        o_sram_wdata = dat_q[{cnt, 3'b000} +: 8];
        o_sram_wen   = wb_issue && we_q && sel_q[cnt];
        if (i_rf_wen) begin
            o_sram_waddr = RF_BASE + aw'(i_rf_waddr);
            o_sram_wdata = i_rf_wdata;
            o_sram_wen   = 1'b1;
        end
    end

    always_comb begin
        o_sram_raddr = wb_addr;
        o_sram_ren   = wb_issue && !we_q;
        if (i_rf_ren) begin
            o_sram_raddr = RF_BASE + aw'(i_rf_raddr);
            o_sram_ren   = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wb_start) state_nxt = XFER;
            XFER:    if (wb_issue && (cnt == 2'd3)) state_nxt = we_q ? ACK : WAIT_RD;
            WAIT_RD: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cnt      <= 2'd0;
            rd_pend  <= 1'b0;
            rd_lane  <= 2'd0;
            o_wb_rdt <= '0;
        end else begin
            state <= state_nxt;
            if (wb_start) begin
                adr_q <= i_wb_adr;
                dat_q <= i_wb_dat;
                sel_q <= i_wb_sel;
                we_q  <= i_wb_we;
                cnt   <= 2'd0;
            end else if (wb_issue) begin
                cnt <= cnt + 2'd1;
            end
            // Read data returns one cycle after issue; remember which lane it belongs to.
            rd_pend <= wb_issue && !we_q;
            if (wb_issue) rd_lane <= cnt;
            if (rd_pend) o_wb_rdt[{rd_lane, 3'b000} +: 8] <= i_sram_rdata;
        end
    end

endmodule

// File: tb/tb_servile_sram_arbiter.sv
// tb/tb_servile_sram_arbiter.sv - scoreboard bench for servile_sram_arbiter
module tb_servile_sram_arbiter;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int RFB   = 880;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    i_rf_waddr, i_rf_wdata, i_rf_raddr;
    logic          i_rf_wen, i_rf_ren;
    logic [7:0]    o_rf_rdata;
    logic [AW-1:2] i_wb_adr;
    logic [31:0]   i_wb_dat;
    logic [3:0]    i_wb_sel;
    logic          i_wb_we, i_wb_stb;
    logic [31:0]   o_wb_rdt;
    logic          o_wb_ack;
    logic [AW-1:0] o_sram_waddr, o_sram_raddr;
    logic [7:0]    o_sram_wdata;
    logic          o_sram_wen, o_sram_ren;
    logic [7:0]    sram_rdata;

    logic [7:0]    mem     [0:DEPTH-1];
    logic [7:0]    ref_mem [0:DEPTH-1];
    logic [7:0]    rf_q [$];
    logic [17:0]   wr_q [$];
    logic          prev_ren;
    logic [31:0]   last_rdt;
    int            pass_cnt, fail_cnt, total_cnt;

    always #5 clk = ~clk;

    servile_sram_arbiter #(.depth(DEPTH), .rf_regs(36)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rf_waddr(i_rf_waddr), .i_rf_wdata(i_rf_wdata), .i_rf_wen(i_rf_wen),
        .i_rf_raddr(i_rf_raddr), .i_rf_ren(i_rf_ren), .o_rf_rdata(o_rf_rdata),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_stb(i_wb_stb), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
        .o_sram_waddr(o_sram_waddr), .o_sram_wdata(o_sram_wdata), .o_sram_wen(o_sram_wen),
        .o_sram_raddr(o_sram_raddr), .o_sram_ren(o_sram_ren), .i_sram_rdata(sram_rdata)
    );

    always @(posedge clk) begin
        if (o_sram_wen) mem[o_sram_waddr] <= o_sram_wdata;
        if (o_sram_ren) sram_rdata <= mem[o_sram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle scoreboard: RF read data, RF port routing and Wishbone byte writes.
    task automatic cycle_chk();
        logic [7:0]  e;
        logic [17:0] w;
        int          a;
        if (prev_ren) begin
            e = rf_q.pop_front();
            check("rf_rdata", {24'd0, o_rf_rdata}, {24'd0, e});
        end
        if (i_rf_ren) begin
            a = RFB + int'(i_rf_raddr);
            check("rf_raddr", {22'd0, o_sram_raddr}, a);
            check("rf_ren", {31'd0, o_sram_ren}, 1);
            rf_q.push_back(ref_mem[a]);
        end
        if (i_rf_wen) begin
            a = RFB + int'(i_rf_waddr);
            check("rf_waddr", {22'd0, o_sram_waddr}, a);
            check("rf_wdata", {24'd0, o_sram_wdata}, {24'd0, i_rf_wdata});
            ref_mem[a] = i_rf_wdata;
        end else if (o_sram_wen) begin
            check("wb_wr_expected", {31'd0, wr_q.size() != 0}, 1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("wb_waddr", {22'd0, o_sram_waddr}, {22'd0, w[17:8]});
                check("wb_wdata", {24'd0, o_sram_wdata}, {24'd0, w[7:0]});
                ref_mem[w[17:8]] = w[7:0];
            end
        end
        prev_ren = i_rf_ren;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        i_wb_stb = 1'b0;
        i_rf_ren = 1'b0;
        i_rf_wen = 1'b0;
        #1;
        cycle_chk();
    endtask

    task automatic wb_op(input string tag, input logic [7:0] wadr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input logic [15:0] ren_m,
                         input logic [15:0] wen_m, input logic [7:0] rfwa, input logic [7:0] rfwd,
                         input int exp_ack);
        int          base;
        logic [31:0] exp_rdt;
        logic        acked;
        base    = int'({wadr, 2'b00});
        acked   = 1'b0;
        exp_rdt = '0;
        if (we) begin
            for (int l = 0; l < 4; l++)
                if (sel[l]) wr_q.push_back({10'(base + l), dat[8*l +: 8]});
        end else begin
            for (int l = 0; l < 4; l++) exp_rdt[8*l +: 8] = ref_mem[base + l];
        end
        for (int c = 0; c < 24 && !acked; c++) begin
            @(negedge clk);
            i_wb_stb   = 1'b1;
            i_wb_adr   = wadr;
            i_wb_dat   = dat;
            i_wb_sel   = sel;
            i_wb_we    = we;
            i_rf_ren   = (c < 16) ? ren_m[c[3:0]] : 1'b0;
            i_rf_raddr = 8'(c);
            i_rf_wen   = (c < 16) ? wen_m[c[3:0]] : 1'b0;
            i_rf_waddr = rfwa;
            i_rf_wdata = rfwd;
            #1;
            cycle_chk();
            if (o_wb_ack) begin
                acked = 1'b1;
                check({tag, "_ack_cycle"}, c, exp_ack);
                if (we) check({tag, "_rdt_held"}, o_wb_rdt, last_rdt);
                else begin
                    check({tag, "_rdt"}, o_wb_rdt, exp_rdt);
                    last_rdt = exp_rdt;
                end
            end
        end
        check({tag, "_acked"}, {31'd0, acked}, 1);
        check({tag, "_writes_done"}, wr_q.size(), 0);
        idle_cycle();
        check({tag, "_ack_one_cycle"}, {31'd0, o_wb_ack}, 0);
    endtask

    initial begin
        logic busy;
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        prev_ren = 1'b0;
        last_rdt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        rst = 1'b1;
        i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0;
        i_rf_wen = 1'b0; i_rf_ren = 1'b0; i_rf_waddr = '0; i_rf_wdata = '0; i_rf_raddr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ack", {31'd0, o_wb_ack}, 0);
        check("reset_rdt", o_wb_rdt, 0);
        check("reset_wen", {31'd0, o_sram_wen}, 0);
        check("reset_ren", {31'd0, o_sram_ren}, 0);

        // RF read of register byte 0 lands at the bottom of the RF region.
        @(negedge clk);
        i_rf_ren = 1'b1;
        i_rf_raddr = 8'h00;
        #1;
        cycle_chk();
        idle_cycle();

        wb_op("wr_full", 8'h10, 32'hAABBCCDD, 4'hF, 1'b1, 16'h0, 16'h0, 8'h0, 8'h0, 5);
        wb_op("wr_sel5", 8'h11, 32'h11223344, 4'h5, 1'b1, 16'h0, 16'h0, 8'h0, 8'h0, 5);
        check("sel5_lane1_kept", {24'd0, mem[16'h45]}, {24'd0, 8'(16'h45 * 7 + 3)});
        check("sel5_lane2", {24'd0, mem[16'h46]}, 32'h22);

        wb_op("rd_stall", 8'h10, 32'h0, 4'h0, 1'b0, 16'h000C, 16'h0, 8'h0, 8'h0, 8);

        // RF and WB write the same byte; the RF wins C1 and the WB byte lands afterwards.
        wb_op("wr_clash", 8'd220, 32'h01020304, 4'h1, 1'b1, 16'h0, 16'h0002, 8'h00, 8'hEE, 6);
        check("clash_final", {24'd0, mem[RFB]}, 32'h04);

        // Reset part-way through a read aborts it without an ack.
        @(negedge clk);
        i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 8'h10; i_wb_sel = 4'hF;
        #1; cycle_chk();
        @(negedge clk); #1; cycle_chk();
        @(negedge clk); #1; cycle_chk();
        rst = 1'b1;
        i_wb_stb = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_ack", {31'd0, o_wb_ack}, 0);
        rst = 1'b0;
        last_rdt = '0;
        busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle_cycle();
            busy = busy | o_wb_ack | o_sram_ren | o_sram_wen;
        end
        check("rst_mid_idle", {31'd0, busy}, 0);
        check("rst_mid_rdt", o_wb_rdt, 0);
        wb_op("rd_reissue", 8'h10, 32'h0, 4'h0, 1'b0, 16'h0, 16'h0, 8'h0, 8'h0, 6);
        check("reissue_value", last_rdt, 32'hAABBCCDD);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
